// File: rtl/mii_mac_rx_pkg.sv
// rtl/mii_mac_rx_pkg.sv - MII receive constants, FSM state type and nibble CRC-32 step
package mii_mac_rx_pkg;

  localparam logic [3:0]  MII_PREAMBLE  = 4'h5;
  localparam logic [3:0]  MII_SFD       = 4'hd;
  localparam logic [31:0] CRC32_POLY    = 32'hedb88320;
  localparam logic [31:0] CRC32_INIT    = 32'hffffffff;
  localparam logic [31:0] CRC32_RESIDUE = 32'hdebb20e3;

  typedef enum logic [1:0] {
    ST_DROP,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA
  } rx_state_e;

  // Reflected CRC-32 advanced by one nibble, LSB first as it arrives on MII.
  function automatic logic [31:0] crc32_nibble_step(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_mac_rx_crc32_nibble.sv
// rtl/mii_mac_rx_crc32_nibble.sv - CRC-32 register updated one MII nibble per ce
module crc32_nibble
  import mii_mac_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        ce,
  input  logic [3:0]  nibble,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC32_INIT;
    end else if (ce) begin
      crc_d = crc32_nibble_step(crc_q, nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mii_mac_rx.sv
// rtl/mii_mac_rx.sv - MII nibble receiver to byte stream; FCS check under MII_MAC_RX_FCS_EN
module mii_mac_rx
  import mii_mac_rx_pkg::*;
#(
  parameter int MAX_LEN = 1522
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_ce,
  input  logic       rx_dv,
  input  logic [3:0] rxd,
  input  logic       rx_er,
  output logic [7:0] data,
  output logic       valid,
  output logic       last,
  output logic       err,
  output logic       receiving
);

  localparam int CW = $clog2(MAX_LEN + 1);

  rx_state_e      state_q, state_d;
  logic           phase_q, phase_d;
  logic [3:0]     low_q, low_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [CW-1:0]  count_q, count_d;
  logic           sticky_q, sticky_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           err_q, err_d;
  logic           receiving_q, receiving_d;
  logic           crc_init, crc_ce;
  logic           fcs_bad;

`ifdef MII_MAC_RX_FCS_EN
  logic [31:0] crc_val;

  crc32_nibble u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (crc_init),
    .ce     (crc_ce),
    .nibble (rxd),
    .crc    (crc_val)
  );

  assign fcs_bad = (crc_val != CRC32_RESIDUE);
`else
  logic unused_crc;
  assign unused_crc = ^{crc_init, crc_ce};
  assign fcs_bad    = 1'b0;
`endif

  // One byte is always held back so the final byte can carry last/err when rx_dv falls.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    low_d       = low_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    count_d     = count_q;
    sticky_d    = sticky_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    err_d       = 1'b0;
    receiving_d = receiving_q;
    crc_init    = 1'b0;
    crc_ce      = 1'b0;
    if (rx_ce) begin
      unique case (state_q)
        ST_DROP: begin
          if (!rx_dv) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (rx_dv) state_d = (rxd == MII_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
        end
        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state_d = ST_IDLE;
          end else if (rxd == MII_SFD) begin
            state_d     = ST_DATA;
            phase_d     = 1'b0;
            hold_full_d = 1'b0;
            count_d     = '0;
            sticky_d    = 1'b0;
            receiving_d = 1'b1;
            crc_init    = 1'b1;
          end else if (rxd != MII_PREAMBLE) begin
            state_d = ST_DROP;
          end
        end
        ST_DATA: begin
          if (!rx_dv) begin
            state_d     = ST_IDLE;
            receiving_d = 1'b0;
            if (hold_full_q) begin
              data_d  = hold_q;
              valid_d = 1'b1;
              last_d  = 1'b1;
              err_d   = sticky_q | phase_q | fcs_bad;
            end
          end else begin
            crc_ce = 1'b1;
            if (rx_er) sticky_d = 1'b1;
            if (!phase_q) begin
              low_d   = rxd;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (count_q == CW'(MAX_LEN)) begin
                data_d      = hold_q;
                valid_d     = 1'b1;
                last_d      = 1'b1;
                err_d       = 1'b1;
                state_d     = ST_DROP;
                receiving_d = 1'b0;
              end else begin
                count_d     = count_q + CW'(1);
                hold_d      = {rxd, low_q};
                hold_full_d = 1'b1;
                if (hold_full_q) begin
                  data_d  = hold_q;
                  valid_d = 1'b1;
                end
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_DROP;
      phase_q     <= 1'b0;
      low_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      count_q     <= '0;
      sticky_q    <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      receiving_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      low_q       <= low_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      count_q     <= count_d;
      sticky_q    <= sticky_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
      receiving_q <= receiving_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign last      = last_q;
  assign err       = err_q;
  assign receiving = receiving_q;

endmodule

// File: tb/tb_mii_mac_rx.sv
// tb/tb_mii_mac_rx.sv - scoreboard bench for mii_mac_rx; honours MII_MAC_RX_FCS_EN
module tb_mii_mac_rx;

  localparam int MAX_LEN = 1522;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_ce = 1'b0;
  logic       rx_dv = 1'b0;
  logic [3:0] rxd = 4'h0;
  logic       rx_er = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       err;
  logic       receiving;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] frame [0:1599];
  logic [9:0] sb [$];

`ifdef MII_MAC_RX_FCS_EN
  localparam logic FCS_ON = 1'b1;
`else
  localparam logic FCS_ON = 1'b0;
`endif

  mii_mac_rx #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_ce     (rx_ce),
    .rx_dv     (rx_dv),
    .rxd       (rxd),
    .rx_er     (rx_er),
    .data      (data),
    .valid     (valid),
    .last      (last),
    .err       (err),
    .receiving (receiving)
  );

  always #4 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check_eq("data", {24'd0, data}, {24'd0, e[7:0]});
        check_eq("last", {31'd0, last}, {31'd0, e[8]});
        check_eq("err", {31'd0, err}, {31'd0, e[9]});
      end
    end
  end

  // Random payload; when fcs is set the final 4 bytes are the standard FCS, LSB first.
  task automatic build_frame(input int n, input logic fcs);
    logic [31:0] c;
    for (int i = 0; i < n; i++) frame[i] = 8'($urandom);
    if (fcs) begin
      c = 32'hffffffff;
      for (int i = 0; i < n - 4; i++) begin
        c = c ^ {24'd0, frame[i]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
      end
      c = ~c;
      for (int b = 0; b < 4; b++) frame[n - 4 + b] = c[8*b +: 8];
    end
  endtask

  task automatic push_exp(input int n_emit, input logic has_last, input logic err_last);
    for (int i = 0; i < n_emit; i++) begin
      logic is_last;
      is_last = has_last && (i == n_emit - 1);
      sb.push_back({is_last & err_last, is_last, frame[i]});
    end
  endtask

  task automatic send_nib(input logic dv, input logic [3:0] n, input logic er);
    @(negedge clk);
    rx_ce = 1'b1; rx_dv = dv; rxd = n; rx_er = er;
    @(negedge clk);
    rx_ce = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_gap(input int n);
    for (int i = 0; i < n; i++) send_nib(1'b0, 4'h0, 1'b0);
  endtask

  task automatic send_frame(input int n_bytes, input int nib_limit, input int er_nib,
                            input int rst_byte, input logic bad_pre);
    int total;
    for (int i = 0; i < 15; i++) send_nib(1'b1, (bad_pre && i == 13) ? 4'h7 : 4'h5, 1'b0);
    send_nib(1'b1, 4'hd, 1'b0);
    check_eq("receiving_after_sfd", {31'd0, receiving}, {31'd0, !bad_pre});
    total = (nib_limit >= 0) ? nib_limit : 2 * n_bytes;
    for (int i = 0; i < total; i++) begin
      logic [7:0] b;
      b = frame[i / 2];
      send_nib(1'b1, (i % 2 == 0) ? b[3:0] : b[7:4], i == er_nib);
      if (rst_byte > 0 && i == 2 * rst_byte - 1) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_receiving", {31'd0, receiving}, 32'd0);
        check_eq("rst_data", {24'd0, data}, 32'd0);
        rst_n = 1'b1;
      end
    end
    send_gap(4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_data", {24'd0, data}, 32'd0);
    check_eq("reset_valid", {31'd0, valid}, 32'd0);
    check_eq("reset_last", {31'd0, last}, 32'd0);
    check_eq("reset_err", {31'd0, err}, 32'd0);
    check_eq("reset_receiving", {31'd0, receiving}, 32'd0);
    rst_n = 1'b1;
    send_gap(3);

    build_frame(64, 1'b1);
    push_exp(64, 1'b1, 1'b0);
    send_frame(64, -1, -1, 0, 1'b0);

    build_frame(64, 1'b1);
    frame[63] = ~frame[63];
    push_exp(64, 1'b1, FCS_ON);
    send_frame(64, -1, -1, 0, 1'b0);

    build_frame(64, 1'b1);
    push_exp(64, 1'b1, 1'b1);
    send_frame(64, -1, 20, 0, 1'b0);

    build_frame(64, 1'b1);
    push_exp(4, 1'b1, 1'b1);
    send_frame(64, 9, -1, 0, 1'b0);

    build_frame(MAX_LEN + 10, 1'b0);
    push_exp(MAX_LEN, 1'b1, 1'b1);
    send_frame(MAX_LEN + 10, -1, -1, 0, 1'b0);

    build_frame(64, 1'b1);
    push_exp(64, 1'b1, 1'b0);
    send_frame(64, -1, -1, 0, 1'b0);

    build_frame(64, 1'b1);
    push_exp(19, 1'b0, 1'b0);
    send_frame(64, -1, -1, 20, 1'b0);
    check_eq("sb_empty_after_rst", sb.size(), 32'd0);

    build_frame(64, 1'b1);
    push_exp(64, 1'b1, 1'b0);
    send_frame(64, -1, -1, 0, 1'b0);

    build_frame(64, 1'b1);
    send_frame(64, -1, -1, 0, 1'b1);
    check_eq("bad_pre_receiving", {31'd0, receiving}, 32'd0);

    build_frame(64, 1'b1);
    push_exp(64, 1'b1, 1'b0);
    send_frame(64, -1, -1, 0, 1'b0);

    repeat (20) @(negedge clk);
    check_eq("sb_empty_final", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
